// File: rtl/credits_scroll_ctrl.sv
// credits_scroll_ctrl
//   Scrolls a 128x96 px text box (16 cols x 6 rows of 8x16 glyphs) up the
//   screen. It scrolls in from START_Y to HOLD_Y, holds for HOLD_FRAMES
//   frames, then scrolls out until the box top reaches -96. It also produces
//   per-pixel character ROM and glyph coordinates for the box.
// Ports
//   clk, rst            : clock, async active-high reset
//   start, abort        : one-cycle sequence begin / cancel requests
//   frame_tick          : one-cycle pulse per video frame
//   video_on            : visible-area flag
//   pixel_x, pixel_y    : current raster position
//   char_xy             : {1'b0, row[2:0], col[3:0]} (1 clk latency)
//   font_row, font_col  : glyph scanline / pixel column (1 clk latency)
//   text_on             : pixel is inside the visible box (1 clk latency)
//   busy, done          : not idle / completion pulse
module credits_scroll_ctrl #(
  parameter int X0          = 256,
  parameter int START_Y     = 480,
  parameter int HOLD_Y      = 192,
  parameter int SPEED_DIV   = 2,
  parameter int HOLD_FRAMES = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       frame_tick,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic [7:0] char_xy,
  output logic [3:0] font_row,
  output logic [2:0] font_col,
  output logic       text_on,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCROLL_IN, S_HOLD, S_SCROLL_OUT, S_FINISH
  } state_t;

  localparam logic signed [10:0] START_TOP = 11'(START_Y);
  localparam logic signed [10:0] HOLD_TOP  = 11'(HOLD_Y);
  localparam logic signed [10:0] END_TOP   = -11'sd96;
  localparam logic signed [10:0] X0_S      = 11'(X0);
  localparam logic [3:0]         STEP_LAST = 4'(SPEED_DIV - 1);
  localparam logic [9:0]         HOLD_LAST = 10'(HOLD_FRAMES - 1);

  state_t             state_q, state_d;
  logic signed [10:0] top_q, top_d, top_dec;
  logic [3:0]         step_q, step_d;
  logic [9:0]         hold_q, hold_d;
  logic               step_hit;

  logic [7:0]         char_xy_q, char_xy_d;
  logic [3:0]         font_row_q, font_row_d;
  logic [2:0]         font_col_q, font_col_d;
  logic               text_on_q, text_on_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic signed [10:0] rel_x, rel_y;
  logic               inwin, scrolling;

  // Sequencer
  always_comb begin
    state_d  = state_q;
    top_d    = top_q;
    step_d   = step_q;
    hold_d   = hold_q;
    top_dec  = top_q - 11'sd1;
    step_hit = frame_tick && (step_q == STEP_LAST);
    if (abort && state_q != S_IDLE) begin
      // abort wins over any frame_tick work in the same cycle
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (start && !abort) begin
          state_d = S_SCROLL_IN;
          top_d   = START_TOP;
          step_d  = '0;
          hold_d  = '0;
        end
        S_SCROLL_IN: if (frame_tick) begin
          if (step_hit) begin
            step_d = '0;
            top_d  = top_dec;
            if (top_dec == HOLD_TOP) begin
              state_d = S_HOLD;
              hold_d  = '0;
            end
          end else begin
            step_d = step_q + 4'd1;
          end
        end
        S_HOLD: if (frame_tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d = S_SCROLL_OUT;
            step_d  = '0;
          end else begin
            hold_d = hold_q + 10'd1;
          end
        end
        S_SCROLL_OUT: if (frame_tick) begin
          if (step_hit) begin
            step_d = '0;
            top_d  = top_dec;
            if (top_dec == END_TOP) state_d = S_FINISH;
          end else begin
            step_d = step_q + 4'd1;
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Pixel geometry; box rows above/below the screen simply fail the window
  // test, so partial visibility needs no special handling.
  always_comb begin
    rel_x     = signed'({1'b0, pixel_x}) - X0_S;
    rel_y     = signed'({1'b0, pixel_y}) - top_q;
    inwin     = (rel_x >= 11'sd0) && (rel_x <= 11'sd127) &&
                (rel_y >= 11'sd0) && (rel_y <= 11'sd95);
    scrolling = (state_q == S_SCROLL_IN) || (state_q == S_HOLD) ||
                (state_q == S_SCROLL_OUT);
    char_xy_d  = inwin ? {1'b0, rel_y[6:4], rel_x[6:3]} : 8'd0;
    font_row_d = inwin ? rel_y[3:0] : 4'd0;
    font_col_d = inwin ? rel_x[2:0] : 3'd0;
    text_on_d  = inwin && video_on && scrolling;
    // Decoded from the next state so done coincides with the FINISH cycle.
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      top_q      <= START_TOP;
      step_q     <= '0;
      hold_q     <= '0;
      char_xy_q  <= '0;
      font_row_q <= '0;
      font_col_q <= '0;
      text_on_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      top_q      <= top_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
      char_xy_q  <= char_xy_d;
      font_row_q <= font_row_d;
      font_col_q <= font_col_d;
      text_on_q  <= text_on_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign char_xy  = char_xy_q;
  assign font_row = font_row_q;
  assign font_col = font_col_q;
  assign text_on  = text_on_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_credits_scroll_ctrl.sv
// Scoreboard bench: the driver queues expected output snapshots tagged with
// the cycle they must appear in; a monitor on the falling edge pops and
// compares them. dut uses SPEED_DIV=1, dut2 SPEED_DIV=2; both share inputs.
module tb_credits_scroll_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, abort, frame_tick, video_on;
  logic [9:0] pixel_x, pixel_y;
  logic [7:0] char_xy, char_xy2;
  logic [3:0] font_row, font_row2;
  logic [2:0] font_col, font_col2;
  logic       text_on, text_on2, busy, busy2, done, done2;

  always #5 clk = ~clk;

  credits_scroll_ctrl #(.X0(256), .START_Y(100), .HOLD_Y(98), .SPEED_DIV(1),
                        .HOLD_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_tick(frame_tick),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .char_xy(char_xy), .font_row(font_row), .font_col(font_col),
    .text_on(text_on), .busy(busy), .done(done));

  credits_scroll_ctrl #(.X0(256), .START_Y(100), .HOLD_Y(98), .SPEED_DIV(2),
                        .HOLD_FRAMES(3)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .frame_tick(frame_tick),
    .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .char_xy(char_xy2), .font_row(font_row2), .font_col(font_col2),
    .text_on(text_on2), .busy(busy2), .done(done2));

  typedef struct {
    int         cyc;
    string      nm;
    bit         sel;   // 0: dut, 1: dut2
    bit         geo;   // compare char_xy/font_row/font_col/text_on
    logic [7:0] cx;
    logic [3:0] fr;
    logic [2:0] fc;
    logic       ton;
    logic       bsy;
    logic       dn;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  int   n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tick(1);
      frame_tick = 1'b0;
    end
  endtask

  // dly=0: outputs as of the last edge; dly=1: after the next edge.
  task automatic expect_at(input int dly, input string nm, input bit sel,
                           input bit geo, input logic [7:0] cx,
                           input logic [3:0] fr, input logic [2:0] fc,
                           input logic ton, input logic bsy, input logic dn);
    exp_t e;
    e.cyc = cyc + dly; e.nm = nm; e.sel = sel; e.geo = geo; e.cx = cx;
    e.fr = fr; e.fc = fc; e.ton = ton; e.bsy = bsy; e.dn = dn;
    sbq.push_back(e);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (done) n_done++;
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        exp_t e;
        logic [7:0] acx; logic [3:0] afr; logic [2:0] afc;
        logic aton, absy, adn;
        bit ok;
        e = sbq.pop_front();
        acx  = e.sel ? char_xy2  : char_xy;
        afr  = e.sel ? font_row2 : font_row;
        afc  = e.sel ? font_col2 : font_col;
        aton = e.sel ? text_on2  : text_on;
        absy = e.sel ? busy2     : busy;
        adn  = e.sel ? done2     : done;
        ok = (e.cyc == cyc) && (absy === e.bsy) && (adn === e.dn);
        if (e.geo)
          ok = ok && (acx === e.cx) && (afr === e.fr) && (afc === e.fc) &&
               (aton === e.ton);
        n_cmp++;
        if (!ok) begin
          n_bad++;
          $display("FAIL %s @cyc %0d (want %0d): got cx=%h fr=%0d fc=%0d ton=%b busy=%b done=%b, expected cx=%h fr=%0d fc=%0d ton=%b busy=%b done=%b",
                   e.nm, cyc, e.cyc, acx, afr, afc, aton, absy, adn,
                   e.cx, e.fr, e.fc, e.ton, e.bsy, e.dn);
        end
      end
    end
  end

  // Hard bound on run time.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    rst = 1'b1; start = 1'b0; abort = 1'b0; frame_tick = 1'b0;
    video_on = 1'b1; pixel_x = 10'd293; pixel_y = 10'd153;
    tick(2);
    expect_at(0, "reset_state", 0, 1, 8'h00, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    expect_at(0, "reset_state2", 1, 1, 8'h00, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    // start presented at the edge where reset is already low
    rst = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    // geometry sampled while still IDLE: window hit but no text_on
    expect_at(0, "start_edge", 0, 1, 8'h34, 4'd5, 3'd5, 1'b0, 1'b1, 1'b0);
    expect_at(1, "scroll_in_top100", 0, 1, 8'h34, 4'd5, 3'd5, 1'b1, 1'b1, 1'b0);
    tick(1);

    // two ticks -> HOLD at top 98
    pulse(2);
    pixel_y = 10'd151;
    expect_at(1, "hold_geom", 0, 1, 8'h34, 4'd5, 3'd5, 1'b1, 1'b1, 1'b0);
    tick(1);
    pixel_x = 10'd255;
    expect_at(1, "left_of_box", 0, 1, 8'h00, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    tick(1);
    pixel_x = 10'd293; pixel_y = 10'd194;
    expect_at(1, "below_box", 0, 1, 8'h00, 4'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    tick(1);
    pixel_y = 10'd151; video_on = 1'b0;
    expect_at(1, "video_off", 0, 1, 8'h34, 4'd5, 3'd5, 1'b0, 1'b1, 1'b0);
    tick(1);
    video_on = 1'b1; pixel_x = 10'd383; pixel_y = 10'd193;
    expect_at(1, "box_corner", 0, 1, 8'h5F, 4'd15, 3'd7, 1'b1, 1'b1, 1'b0);
    tick(1);

    // three hold ticks -> SCROLL_OUT, top still 98
    pixel_x = 10'd293; pixel_y = 10'd151;
    pulse(3);
    expect_at(1, "scroll_out_top98", 0, 1, 8'h34, 4'd5, 3'd5, 1'b1, 1'b1, 1'b0);
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    expect_at(1, "start_ignored", 0, 1, 8'h34, 4'd5, 3'd5, 1'b1, 1'b1, 1'b0);
    tick(1);

    pulse(10);
    pixel_y = 10'd141;
    expect_at(1, "scroll_out_top88", 0, 1, 8'h34, 4'd5, 3'd5, 1'b1, 1'b1, 1'b0);
    tick(1);
    pulse(183);
    // top = -95: only the last scanline of row 5 is on screen
    pixel_y = 10'd0;
    expect_at(1, "clip_top_m95", 0, 1, 8'h54, 4'd15, 3'd5, 1'b1, 1'b1, 1'b0);
    tick(1);
    frame_tick = 1'b1;
    tick(1);
    frame_tick = 1'b0;
    expect_at(0, "done_pulse", 0, 0, 8'h00, 4'd0, 3'd0, 1'b0, 1'b1, 1'b1);
    expect_at(1, "idle_after_done", 0, 0, 8'h00, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(3);
    nd = n_done;
    n_cmp++;
    if (nd != 1) begin
      n_bad++;
      $display("FAIL done_count: got %0d, expected 1", nd);
    end

    // abort in HOLD coincident with frame_tick
    start = 1'b1;
    tick(1);
    start = 1'b0;
    pulse(3);
    frame_tick = 1'b1; abort = 1'b1;
    tick(1);
    frame_tick = 1'b0; abort = 1'b0;
    expect_at(0, "abort_idle", 0, 0, 8'h00, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(5);
    nd = n_done;
    n_cmp++;
    if (nd != 1) begin
      n_bad++;
      $display("FAIL abort_no_done: got %0d, expected 1", nd);
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    pixel_y = 10'd153;
    expect_at(1, "restart_top100", 0, 1, 8'h34, 4'd5, 3'd5, 1'b1, 1'b1, 1'b0);
    tick(1);

    // async reset mid SCROLL_IN: visible before the next rising edge
    pulse(1);
    rst = 1'b1;
    #1;
    expect_at(0, "async_reset", 0, 1, 8'h00, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(1);

    // abort and start together while idle
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    expect_at(0, "start_abort_idle", 0, 0, 8'h00, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick(1);

    // SPEED_DIV=2 instance
    start = 1'b1;
    tick(1);
    start = 1'b0;
    pulse(1);
    expect_at(1, "div2_one_tick", 1, 1, 8'h34, 4'd5, 3'd5, 1'b1, 1'b1, 1'b0);
    tick(6);
    expect_at(1, "div2_no_tick", 1, 1, 8'h34, 4'd5, 3'd5, 1'b1, 1'b1, 1'b0);
    tick(1);
    pulse(1);
    expect_at(1, "div2_two_ticks", 1, 1, 8'h34, 4'd6, 3'd5, 1'b1, 1'b1, 1'b0);
    tick(3);

    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
